// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a single-port memory between an instruction-fetch requester (if_*)
// and a load/store requester (ls_*). Grants are issued combinationally in IDLE.
// The winning access is captured into registers on the grant edge. Those
// registers drive the memory until mem_ready is sampled. The requester gets a
// one-cycle rvalid pulse in the following cycle, which is also an IDLE cycle,
// so back-to-back grants are possible.
//
// Priority: load/store wins over fetch. The exception is when fetch has lost
// STARVE_LIMIT consecutive arbitrations; fetch then wins the next one.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   Defined   : an access with no mem_ready for TIMEOUT+1 cycles of mem_req is
//               aborted. The next cycle pulses err and x_rvalid, with
//               x_rdata = 32'hDEADBEEF.
//   Undefined : no timeout counter exists, err is tied low, and the FSM waits
//               for mem_ready indefinitely.
//
// Parameters
//   STARVE_LIMIT  consecutive lost arbitrations after which fetch wins
//   TIMEOUT       memory wait-cycle limit (timeout build only)
//
// Ports
//   clk, nreset                      clock (rising edge), async active-low reset
//   if_req/if_addr -> if_gnt         fetch request, address, and grant
//   if_rvalid/if_rdata               fetch completion pulse and instruction
//   ls_req/ls_rw/ls_addr/ls_wdata    load/store request (rw: 1 = write)
//   ls_gnt, ls_rvalid/ls_rdata       load/store grant, completion, and load data
//   mem_req/mem_rw/mem_addr/mem_wdata  memory access (all zero when idle)
//   mem_ready/mem_rdata              memory completion and read data
//   err                              one-cycle pulse on a timed-out access
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_rw,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        mem_req,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   // Reject parameter values for which starvation or timeout is meaningless.
   if (STARVE_LIMIT < 1 || TIMEOUT < 1) begin : g_param_check
      $error("mem_arbiter: STARVE_LIMIT and TIMEOUT must both be >= 1");
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_t;

   state_t        state_r;
   logic [SW-1:0] starve_cnt_r;
   logic          starved_s;
   logic          if_win_s;
   logic          ls_win_s;
   logic          mem_req_r;
   logic          mem_rw_r;
   logic [31:0]   mem_addr_r;
   logic [31:0]   mem_wdata_r;
   logic          if_rvalid_r;
   logic          ls_rvalid_r;
   logic [31:0]   if_rdata_r;
   logic [31:0]   ls_rdata_r;
`ifdef MEM_ARB_TIMEOUT_EN
   logic [TW-1:0] tmo_cnt_r;
   logic          err_r;
`endif

   // Same-cycle arbitration. Only IDLE may grant. Reset suppresses grants so
   // that every output reads 0 while nreset is low.
   always_comb begin
      if_win_s  = 1'b0;
      ls_win_s  = 1'b0;
      starved_s = (starve_cnt_r == STARVE_MAX);
      if (nreset && (state_r == IDLE)) begin
         if (if_req && (!ls_req || starved_s)) begin
            if_win_s = 1'b1;
         end else if (ls_req) begin
            ls_win_s = 1'b1;
         end else begin
            if_win_s = 1'b0;
         end
      end else begin
         ls_win_s = 1'b0;
      end
   end

   // Arbiter FSM: captures the winning access, runs it against memory, and
   // returns completion data.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r      <= IDLE;
         starve_cnt_r <= {SW{1'b0}};
         mem_req_r    <= 1'b0;
         mem_rw_r     <= 1'b0;
         mem_addr_r   <= 32'h0000_0000;
         mem_wdata_r  <= 32'h0000_0000;
         if_rvalid_r  <= 1'b0;
         ls_rvalid_r  <= 1'b0;
         if_rdata_r   <= 32'h0000_0000;
         ls_rdata_r   <= 32'h0000_0000;
`ifdef MEM_ARB_TIMEOUT_EN
         tmo_cnt_r    <= {TW{1'b0}};
         err_r        <= 1'b0;
`endif
      end else begin
         // Completion strobes are single-cycle pulses.
         if_rvalid_r <= 1'b0;
         ls_rvalid_r <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         err_r       <= 1'b0;
`endif
         case (state_r)
            IDLE: begin
               if (if_win_s) begin
                  state_r      <= BUSY_IF;
                  mem_req_r    <= 1'b1;
                  mem_rw_r     <= 1'b0;
                  mem_addr_r   <= if_addr;
                  mem_wdata_r  <= 32'h0000_0000;
                  starve_cnt_r <= {SW{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
                  tmo_cnt_r    <= {TW{1'b0}};
`endif
               end else if (ls_win_s) begin
                  state_r     <= BUSY_LS;
                  mem_req_r   <= 1'b1;
                  mem_rw_r    <= ls_rw;
                  mem_addr_r  <= ls_addr;
                  mem_wdata_r <= ls_wdata;
                  // A pending fetch has just lost; count it, saturating.
                  if (if_req && !starved_s) begin
                     starve_cnt_r <= starve_cnt_r + SW'(1'b1);
                  end
`ifdef MEM_ARB_TIMEOUT_EN
                  tmo_cnt_r   <= {TW{1'b0}};
`endif
               end
            end
            BUSY_IF, BUSY_LS: begin
               if (mem_ready) begin
                  state_r     <= IDLE;
                  mem_req_r   <= 1'b0;
                  mem_rw_r    <= 1'b0;
                  mem_addr_r  <= 32'h0000_0000;
                  mem_wdata_r <= 32'h0000_0000;
                  if (state_r == BUSY_IF) begin
                     if_rvalid_r <= 1'b1;
                     if_rdata_r  <= mem_rdata;
                  end else begin
                     ls_rvalid_r <= 1'b1;
                     // Stores return zero rather than whatever is on the bus.
                     ls_rdata_r  <= mem_rw_r ? 32'h0000_0000 : mem_rdata;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               // The access has already waited TIMEOUT cycles; this one is
               // its last chance, so abort it with a poison value.
               else if (tmo_cnt_r == TMO_MAX) begin
                  state_r     <= IDLE;
                  mem_req_r   <= 1'b0;
                  mem_rw_r    <= 1'b0;
                  mem_addr_r  <= 32'h0000_0000;
                  mem_wdata_r <= 32'h0000_0000;
                  err_r       <= 1'b1;
                  if (state_r == BUSY_IF) begin
                     if_rvalid_r <= 1'b1;
                     if_rdata_r  <= 32'hDEAD_BEEF;
                  end else begin
                     ls_rvalid_r <= 1'b1;
                     ls_rdata_r  <= 32'hDEAD_BEEF;
                  end
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
               end
`endif
            end
            default: begin
               state_r     <= IDLE;
               mem_req_r   <= 1'b0;
               mem_rw_r    <= 1'b0;
               mem_addr_r  <= 32'h0000_0000;
               mem_wdata_r <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign if_gnt    = if_win_s;
   assign ls_gnt    = ls_win_s;
   assign if_rvalid = if_rvalid_r;
   assign ls_rvalid = ls_rvalid_r;
   assign if_rdata  = if_rdata_r;
   assign ls_rdata  = ls_rdata_r;
   assign mem_req   = mem_req_r;
   assign mem_rw    = mem_rw_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
`ifdef MEM_ARB_TIMEOUT_EN
   assign err       = err_r;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A transaction-level reference model tracks
// the current owner, the captured access, the lost-arbitration count, and the
// completion pulses. A compare process checks every DUT output against that
// model on each falling edge. The stimulus also pins key cycles with
// hand-computed literals. A small memory responder supplies mem_ready after a
// programmable number of wait states and can be told to hang.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 16;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req = 1'b0;
   logic        ls_rw = 1'b0;
   logic [31:0] ls_addr = 32'h0;
   logic [31:0] ls_wdata = 32'h0;
   logic        ls_gnt, ls_rvalid;
   logic [31:0] ls_rdata;
   logic        mem_req, mem_rw;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        err;

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .nreset(nreset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h expected=%08h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int mem_wait = 0;
   logic mem_hang = 1'b0;
   int wcnt = 0;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h00A0_0093;
      else return a ^ 32'hA5A5_0000;
   endfunction

   always begin
      @(posedge clk);
      #2;
      if (!mem_req) begin
         wcnt = 0;
         mem_ready = 1'b0;
         mem_rdata = 32'h0;
      end else if (!mem_hang && wcnt >= mem_wait) begin
         mem_ready = 1'b1;
         mem_rdata = memval(mem_addr);
      end else begin
         mem_ready = 1'b0;
         mem_rdata = 32'h1234_5678;
         wcnt++;
      end
   end

   // ---------------- reference model ----------------
   int          m_owner = 0;       // 0 = none, 1 = fetch, 2 = load/store
   logic        m_rw = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   int          m_losses = 0;      // consecutive fetch losses
   int          m_high = 0;        // completed cycles with mem_req high
   logic        m_if_rv = 1'b0, m_ls_rv = 1'b0, m_err = 1'b0;
   logic [31:0] m_if_rd = 32'h0, m_ls_rd = 32'h0;

   function automatic logic want_if();
      return nreset && (m_owner == 0) && if_req &&
             (!ls_req || (m_losses >= STARVE_LIMIT));
   endfunction

   function automatic logic want_ls();
      return nreset && (m_owner == 0) && ls_req && !want_if();
   endfunction

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m_owner <= 0; m_rw <= 1'b0; m_addr <= 32'h0; m_wdata <= 32'h0;
         m_losses <= 0; m_high <= 0;
         m_if_rv <= 1'b0; m_ls_rv <= 1'b0; m_err <= 1'b0;
         m_if_rd <= 32'h0; m_ls_rd <= 32'h0;
      end else begin
         m_if_rv <= 1'b0;
         m_ls_rv <= 1'b0;
         m_err   <= 1'b0;
         if (m_owner != 0) begin
            if (mem_ready) begin
               m_owner <= 0;
               if (m_owner == 1) begin
                  m_if_rv <= 1'b1;
                  m_if_rd <= mem_rdata;
               end else begin
                  m_ls_rv <= 1'b1;
                  m_ls_rd <= m_rw ? 32'h0 : mem_rdata;
               end
            end else begin
               m_high <= m_high + 1;
`ifdef MEM_ARB_TIMEOUT_EN
               if (m_high + 1 > TIMEOUT) begin
                  m_owner <= 0;
                  m_err   <= 1'b1;
                  if (m_owner == 1) begin
                     m_if_rv <= 1'b1;
                     m_if_rd <= 32'hDEAD_BEEF;
                  end else begin
                     m_ls_rv <= 1'b1;
                     m_ls_rd <= 32'hDEAD_BEEF;
                  end
               end
`endif
            end
         end else if (want_if()) begin
            m_owner <= 1; m_rw <= 1'b0; m_addr <= if_addr; m_wdata <= 32'h0;
            m_losses <= 0; m_high <= 0;
         end else if (want_ls()) begin
            m_owner <= 2; m_rw <= ls_rw; m_addr <= ls_addr; m_wdata <= ls_wdata;
            m_high <= 0;
            if (if_req) m_losses <= m_losses + 1;
         end
      end
   end

   // Compare every DUT output with the model once per cycle, away from the edge.
   always @(negedge clk) begin
      chk("if_gnt",    {31'h0, if_gnt},    {31'h0, want_if()});
      chk("ls_gnt",    {31'h0, ls_gnt},    {31'h0, want_ls()});
      chk("mem_req",   {31'h0, mem_req},   {31'h0, (m_owner != 0)});
      chk("mem_rw",    {31'h0, mem_rw},    {31'h0, (m_owner != 0) ? m_rw : 1'b0});
      chk("mem_addr",  mem_addr,           (m_owner != 0) ? m_addr : 32'h0);
      // Write data during a fetch is not defined, so it is not checked then.
      if (m_owner != 1) chk("mem_wdata", mem_wdata, (m_owner != 0) ? m_wdata : 32'h0);
      chk("if_rvalid", {31'h0, if_rvalid}, {31'h0, m_if_rv});
      chk("ls_rvalid", {31'h0, ls_rvalid}, {31'h0, m_ls_rv});
      chk("if_rdata",  if_rdata,           m_if_rd);
      chk("ls_rdata",  ls_rdata,           m_ls_rd);
      chk("err",       {31'h0, err},       {31'h0, m_err});
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      #3;
   endtask

   int  n_ls;
   logic got_if;

   initial begin
      // Reset: a request held during reset must not be granted.
      nreset = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      repeat (3) step();
      probe();
      chk("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);

      // Single fetch: grant in N, address in N+1, instruction in N+2.
      step();
      nreset = 1'b1;
      probe();
      chk("fetch_gnt_N", {31'h0, if_gnt}, 32'h1);
      step();
      if_req = 1'b0;
      probe();
      chk("fetch_mem_req_N1", {31'h0, mem_req}, 32'h1);
      chk("fetch_mem_addr_N1", mem_addr, 32'h0000_0100);
      step();
      probe();
      chk("fetch_rvalid_N2", {31'h0, if_rvalid}, 32'h1);
      chk("fetch_rdata_N2", if_rdata, 32'h00A0_0093);
      step();
      probe();
      chk("fetch_rvalid_pulse", {31'h0, if_rvalid}, 32'h0);
      step();

      // Simultaneous requests: ls wins; fetch is granted in the ls rvalid cycle.
      if_req = 1'b1; if_addr = 32'h0000_0104;
      ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 32'h0000_2000;
      probe();
      chk("sim_ls_gnt", {31'h0, ls_gnt}, 32'h1);
      chk("sim_if_lost", {31'h0, if_gnt}, 32'h0);
      step();
      ls_req = 1'b0;
      probe();
      chk("sim_busy_no_gnt", {31'h0, if_gnt}, 32'h0);
      step();
      probe();
      chk("sim_ls_rvalid", {31'h0, ls_rvalid}, 32'h1);
      chk("sim_ls_rdata", ls_rdata, 32'hA5A5_2000);
      chk("sim_if_gnt_at_rvalid", {31'h0, if_gnt}, 32'h1);
      step();
      if_req = 1'b0;
      step();
      step();

      // Starvation: fetch must win after four consecutive losses.
      if_req = 1'b1; if_addr = 32'h0000_0200;
      ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 32'h0000_3000;
      n_ls = 0;
      got_if = 1'b0;
      for (int i = 0; i < 30 && !got_if; i++) begin
         probe();
         if (if_gnt) got_if = 1'b1;
         else if (ls_gnt) n_ls++;
         step();
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      chk("starve_if_won", {31'h0, got_if}, 32'h1);
      chk("starve_ls_wins_first", n_ls, 32'd4);
      step();
      step();

      // Store with three wait states: outputs stable for four cycles.
      mem_wait = 3;
      ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 32'h0000_0040; ls_wdata = 32'hCAFE_F00D;
      probe();
      chk("store_gnt", {31'h0, ls_gnt}, 32'h1);
      step();
      ls_req = 1'b0; ls_wdata = 32'h0;
      for (int k = 0; k < 4; k++) begin
         probe();
         chk("store_mem_req", {31'h0, mem_req}, 32'h1);
         chk("store_mem_rw", {31'h0, mem_rw}, 32'h1);
         chk("store_mem_addr", mem_addr, 32'h0000_0040);
         chk("store_mem_wdata", mem_wdata, 32'hCAFE_F00D);
         step();
      end
      probe();
      chk("store_rvalid", {31'h0, ls_rvalid}, 32'h1);
      chk("store_rdata_zero", ls_rdata, 32'h0);
      chk("store_mem_idle", {31'h0, mem_req}, 32'h0);
      chk("store_addr_idle", mem_addr, 32'h0);
      step();
      probe();
      chk("store_rvalid_pulse", {31'h0, ls_rvalid}, 32'h0);
      mem_wait = 0;
      step();

      // Reset in the middle of a load: outputs clear at once, no late rvalid.
      mem_wait = 5;
      ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 32'h0000_0080;
      step();
      ls_req = 1'b0;
      step();
      #2;
      nreset = 1'b0;
      #1;
      chk("mrst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("mrst_mem_addr", mem_addr, 32'h0);
      chk("mrst_ls_rdata", ls_rdata, 32'h0);
      chk("mrst_if_rdata", if_rdata, 32'h0);
      chk("mrst_ls_rvalid", {31'h0, ls_rvalid}, 32'h0);
      step();
      step();
      nreset = 1'b1;
      mem_wait = 0;
      for (int k = 0; k < 6; k++) begin
         probe();
         chk("mrst_no_rvalid", {31'h0, ls_rvalid}, 32'h0);
         step();
      end

      // Memory that never answers.
      mem_hang = 1'b1;
      if_req = 1'b1; if_addr = 32'h0000_0300;
      probe();
      chk("hang_gnt", {31'h0, if_gnt}, 32'h1);
      step();
      if_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      for (int k = 0; k < 17; k++) begin
         probe();
         chk("tmo_mem_req", {31'h0, mem_req}, 32'h1);
         chk("tmo_err_early", {31'h0, err}, 32'h0);
         step();
      end
      probe();
      chk("tmo_err", {31'h0, err}, 32'h1);
      chk("tmo_if_rvalid", {31'h0, if_rvalid}, 32'h1);
      chk("tmo_if_rdata", if_rdata, 32'hDEAD_BEEF);
      chk("tmo_mem_idle", {31'h0, mem_req}, 32'h0);
      step();
      probe();
      chk("tmo_err_pulse", {31'h0, err}, 32'h0);
      mem_hang = 1'b0;
      step();
`else
      for (int k = 0; k < 24; k++) begin
         probe();
         chk("hang_mem_req", {31'h0, mem_req}, 32'h1);
         chk("hang_err", {31'h0, err}, 32'h0);
         step();
      end
      mem_hang = 1'b0;
      step();
      probe();
      chk("hang_late_rvalid", {31'h0, if_rvalid}, 32'h1);
      chk("hang_late_rdata", if_rdata, 32'hA5A5_0300);
      step();
`endif
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost arbitrations after which fetch wins.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the memory wait-cycle limit used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have the following ports (name, direction, width, meaning); one clock, reset asynchronous active-low:
- clk  in  1  single clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  32  fetch address (pc).
- if_gnt  out  1  fetch request accepted.
- if_rvalid  out  1  one-cycle pulse, instruction valid.
- if_rdata  out  32  fetched instruction.
- ls_req  in  1  load/store request, held until ls_gnt.
- ls_rw  in  1  1 = write, 0 = read.
- ls_addr  in  32  load/store address.
- ls_wdata  in  32  store data.
- ls_gnt  out  1  load/store request accepted.
- ls_rvalid  out  1  one-cycle pulse, access complete.
- ls_rdata  out  32  load data.
- mem_req  out  1  memory access active.
- mem_rw  out  1  1 = write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory completes access this cycle.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- err  out  1  one-cycle pulse, access aborted by timeout.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS.
REQ-005 In IDLE, arbitration SHALL be combinational:
- gnt is asserted for exactly one requester in the same cycle.
- Next state is BUSY_IF or BUSY_LS.
- addr, wdata and rw are captured into registers on that edge.
REQ-006 Priority SHALL be: ls over if, except that when starve_cnt == STARVE_LIMIT, if wins.
REQ-007 starve_cnt SHALL update as follows:
- Increments when if_req loses arbitration to ls.
- Clears when if is granted.
- Saturates at STARVE_LIMIT.
REQ-008 In BUSY_x, the registered values SHALL drive mem_req=1 and mem_addr/mem_wdata/mem_rw, held stable until the edge sampling mem_ready=1.
REQ-009 On the mem_ready edge, the FSM SHALL:
- Return to IDLE.
- Pulse x_rvalid for one cycle in the following cycle.
- For a read, register mem_rdata into x_rdata.
- For a write, drive ls_rdata to 0.
REQ-010 Minimum latency SHALL be 2 cycles: gnt in cycle N, mem_req in cycle N+1, and with mem_ready in N+1, rvalid in N+2.
REQ-011 The rvalid cycle SHALL be spent in IDLE, so a new grant is possible in the same cycle as rvalid.
REQ-012 No gnt SHALL be asserted outside IDLE; requests are ignored while BUSY.
REQ-013 x_rdata SHALL hold its last value until the next completion for that requester.
REQ-014 When mem_req=0, mem_addr, mem_wdata and mem_rw SHALL be 0.

Reset
REQ-015 Assertion of nreset SHALL asynchronously force the following, including mid-transaction, with any in-flight access dropped without rvalid:
- State to IDLE.
- starve_cnt and the timeout counter to 0.
- All outputs to 0.
REQ-016 After deassertion, the first arbitration SHALL occur on the first rising clk edge.

Configuration
REQ-017 With MEM_ARB_TIMEOUT_EN defined:
- A counter runs in BUSY_x.
- If mem_ready is not seen within TIMEOUT cycles of mem_req, the access is aborted and the FSM goes to IDLE.
- The next cycle pulses err and x_rvalid, with x_rdata = 32'hDEADBEEF.
REQ-018 Without MEM_ARB_TIMEOUT_EN, no timeout counter SHALL exist, err SHALL be tied to 0, and BUSY_x SHALL wait indefinitely for mem_ready.

Verification
REQ-019 Single fetch: if_req=1, if_addr=0x100, mem_ready high on first mem_req cycle with mem_rdata=0x00A00093 -> if_gnt at N, mem_addr=0x100 at N+1, if_rvalid and if_rdata=0x00A00093 at N+2.
REQ-020 Simultaneous requests: if_req and ls_req (read 0x2000) both high -> ls_gnt first; if_gnt at the rvalid cycle of the ls access.
REQ-021 Starvation: ls_req continuously high, if_req high, 0-wait memory -> if wins arbitration 5 (after 4 consecutive losses).
REQ-022 Store with 3 wait states: ls_rw=1, ls_addr=0x40, ls_wdata=0xCAFEF00D -> mem_req held 4 cycles with stable outputs; ls_rvalid one cycle; ls_rdata=0.
REQ-023 Reset mid-access: nreset low during BUSY_LS -> all outputs 0 immediately; no ls_rvalid after release.
REQ-024 Timeout (macro defined): mem_ready held 0 -> err and if_rvalid pulse with if_rdata=0xDEADBEEF 17 cycles after mem_req rises; without the macro, mem_req stays high and err stays 0.
